// File: rtl/ama_riscv_ret_trace_buf_pkg.sv
// Shared types for the retirement trace buffer: trace record layout and
// controller state encoding.
package ama_riscv_ret_trace_buf_pkg;

  localparam logic [3:0] DMEM_SIZE_NA = 4'd8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_size;
    logic        branch_inst;
    logic        branch_taken;
    logic        bp_hit;
  } trace_rec_t;

  typedef enum logic [1:0] {
    RTB_IDLE,
    RTB_RUN,
    RTB_DRAIN,
    RTB_DONE
  } rtb_state_t;

endpackage

// File: rtl/ama_riscv_sync_fifo.sv
// Single-clock FIFO with registered write and combinational read head.
// A push is accepted while full when a pop happens in the same cycle.
module ama_riscv_sync_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  // storage is intentionally unreset; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ama_riscv_ret_trace_buf.sv
// Retirement trace buffer: captures retired-instruction records into a FIFO
// and keeps event counters while armed, draining after tohost is written.
module ama_riscv_ret_trace_buf
  import ama_riscv_ret_trace_buf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             ret_valid,
  input  logic [31:0]      ret_inst,
  input  logic [31:0]      ret_pc,
  input  logic             ret_branch_inst,
  input  logic             ret_branch_taken,
  input  logic             ret_bp_hit,
  input  logic [31:0]      ret_dmem_addr,
  input  logic [3:0]       ret_dmem_size,
  input  logic [31:0]      csr_tohost,
  output logic             trace_valid,
  input  logic             trace_ready,
  output trace_rec_t       trace_rec,
  output logic [CNT_W-1:0] cnt_inst,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_bp_hit,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_drop,
  output logic             overflow,
  output logic             done
);
  localparam int AW = $clog2(DEPTH);

  rtb_state_t    state, state_nxt;
  trace_rec_t    rec_in;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_cnt;
  logic          do_clr, acc, pop_fire, drop, push;

  assign do_clr   = clr && (state == RTB_IDLE || state == RTB_DONE);
  assign acc      = ret_valid && (state == RTB_RUN);
  assign pop_fire = trace_valid && trace_ready;
  assign drop     = acc && fifo_full && !pop_fire;
  assign push     = acc && !drop;

  assign trace_valid = !fifo_empty;
  assign done        = (state == RTB_DONE);

  assign rec_in = '{inst: ret_inst, pc: ret_pc, dmem_addr: ret_dmem_addr,
                    dmem_size: ret_dmem_size, branch_inst: ret_branch_inst,
                    branch_taken: ret_branch_taken, bp_hit: ret_bp_hit};

  ama_riscv_sync_fifo #(.DEPTH(DEPTH), .T(trace_rec_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (do_clr),
    .push  (push),
    .pop   (pop_fire),
    .wdata (rec_in),
    .rdata (trace_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RTB_IDLE;
    else        state <= state_nxt;
  end

  // DRAIN ends on the edge that empties the FIFO, so done follows the last pop
  always_comb begin
    state_nxt = state;
    unique case (state)
      RTB_IDLE:  if (en) state_nxt = RTB_RUN;
      RTB_RUN:   if (!en) state_nxt = RTB_IDLE;
                 else if (csr_tohost != '0) state_nxt = RTB_DRAIN;
      RTB_DRAIN: if (fifo_cnt == (AW+1)'(pop_fire)) state_nxt = RTB_DONE;
      RTB_DONE:  if (clr) state_nxt = RTB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || 1'b0) begin
      cnt_inst   <= '0;
      cnt_branch <= '0;
      cnt_taken  <= '0;
      cnt_bp_hit <= '0;
      cnt_load   <= '0;
      cnt_store  <= '0;
      cnt_drop   <= '0;
      overflow   <= 1'b0;
    end else if (do_clr) begin
      cnt_inst   <= '0;
      cnt_branch <= '0;
      cnt_taken  <= '0;
      cnt_bp_hit <= '0;
      cnt_load   <= '0;
      cnt_store  <= '0;
      cnt_drop   <= '0;
      overflow   <= 1'b0;
    end else if (acc) begin
      cnt_inst <= cnt_inst + CNT_W'(1);
      if (ret_branch_inst)                     cnt_branch <= cnt_branch + CNT_W'(1);
      if (ret_branch_inst && ret_branch_taken) cnt_taken  <= cnt_taken + CNT_W'(1);
      if (ret_branch_inst && ret_bp_hit)       cnt_bp_hit <= cnt_bp_hit + CNT_W'(1);
      if (ret_dmem_size < 4'd4)                cnt_load   <= cnt_load + CNT_W'(1);
      if (ret_dmem_size[3:2] == 2'b01)         cnt_store  <= cnt_store + CNT_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (!(&cnt_drop)) cnt_drop <= cnt_drop + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ama_riscv_ret_trace_buf.sv
// Randomized bench for the retirement trace buffer, checked every cycle
// against a queue-based reference model of the trace/counter behaviour.
module tb_ama_riscv_ret_trace_buf;
  import ama_riscv_ret_trace_buf_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, clr = 1'b0, ret_valid = 1'b0;
  logic [31:0] ret_inst = '0, ret_pc = '0, ret_dmem_addr = '0, csr_tohost = '0;
  logic ret_branch_inst = 1'b0, ret_branch_taken = 1'b0, ret_bp_hit = 1'b0;
  logic [3:0] ret_dmem_size = 4'd8;
  logic trace_valid, trace_ready = 1'b0;
  trace_rec_t trace_rec;
  logic [CNT_W-1:0] cnt_inst, cnt_branch, cnt_taken, cnt_bp_hit, cnt_load, cnt_store, cnt_drop;
  logic overflow, done;

  ama_riscv_ret_trace_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ret_valid(ret_valid),
    .ret_inst(ret_inst), .ret_pc(ret_pc), .ret_branch_inst(ret_branch_inst),
    .ret_branch_taken(ret_branch_taken), .ret_bp_hit(ret_bp_hit),
    .ret_dmem_addr(ret_dmem_addr), .ret_dmem_size(ret_dmem_size),
    .csr_tohost(csr_tohost), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_rec(trace_rec), .cnt_inst(cnt_inst), .cnt_branch(cnt_branch),
    .cnt_taken(cnt_taken), .cnt_bp_hit(cnt_bp_hit), .cnt_load(cnt_load),
    .cnt_store(cnt_store), .cnt_drop(cnt_drop), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // reference model: mode 0 idle, 1 armed, 2 draining, 3 finished
  trace_rec_t  q[$];
  int          m_mode;
  logic [31:0] m_cnt[7]; // inst, branch, taken, bp_hit, load, store, drop
  logic        m_ovf;

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    foreach (m_cnt[i]) m_cnt[i] = '0;
    m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    chk("trace_valid", trace_valid, q.size() != 0);
    if (q.size() != 0) chk("trace_rec", trace_rec, q[0]);
    chk("cnt_inst", cnt_inst, m_cnt[0]);
    chk("cnt_branch", cnt_branch, m_cnt[1]);
    chk("cnt_taken", cnt_taken, m_cnt[2]);
    chk("cnt_bp_hit", cnt_bp_hit, m_cnt[3]);
    chk("cnt_load", cnt_load, m_cnt[4]);
    chk("cnt_store", cnt_store, m_cnt[5]);
    chk("cnt_drop", cnt_drop, m_cnt[6]);
    chk("overflow", overflow, m_ovf);
    chk("done", done, m_mode == 3);
  endtask

  // advance model by one clock using the currently driven inputs, then clock
  // the DUT and compare on the falling edge
  task automatic step();
    bit pop_f;
    int nm;
    trace_rec_t r;
    pop_f = (q.size() != 0) && trace_ready;
    nm    = m_mode;
    r     = '{inst: ret_inst, pc: ret_pc, dmem_addr: ret_dmem_addr, dmem_size: ret_dmem_size,
              branch_inst: ret_branch_inst, branch_taken: ret_branch_taken, bp_hit: ret_bp_hit};
    if (clr && (m_mode == 0 || m_mode == 3)) begin
      q.delete();
      foreach (m_cnt[i]) m_cnt[i] = '0;
      m_ovf = 1'b0;
    end else begin
      if (pop_f) void'(q.pop_front());
      if (ret_valid && m_mode == 1) begin
        m_cnt[0] = m_cnt[0] + 1;
        if (ret_branch_inst) m_cnt[1] = m_cnt[1] + 1;
        if (ret_branch_inst && ret_branch_taken) m_cnt[2] = m_cnt[2] + 1;
        if (ret_branch_inst && ret_bp_hit) m_cnt[3] = m_cnt[3] + 1;
        if (ret_dmem_size <= 3) m_cnt[4] = m_cnt[4] + 1;
        else if (ret_dmem_size <= 7) m_cnt[5] = m_cnt[5] + 1;
        if (q.size() == DEPTH) begin
          if (m_cnt[6] != 32'hFFFF_FFFF) m_cnt[6] = m_cnt[6] + 1;
          m_ovf = 1'b1;
        end else q.push_back(r);
      end
    end
    case (m_mode)
      0: if (en) nm = 1;
      1: if (!en) nm = 0; else if (csr_tohost != 0) nm = 2;
      2: if (q.size() == 0) nm = 3;
      3: if (clr) nm = 0;
      default: nm = 0;
    endcase
    m_mode = nm;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_ret(input bit v, input logic [3:0] sz, input bit br, input bit tk, input bit hit);
    ret_valid        = v;
    ret_inst         = $urandom;
    ret_pc           = $urandom;
    ret_dmem_addr    = $urandom;
    ret_dmem_size    = sz;
    ret_branch_inst  = br;
    ret_branch_taken = tk;
    ret_bp_hit       = hit;
  endtask

  task automatic rand_ret(input bit v);
    set_ret(v, 4'($urandom_range(0, 8)), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // leave RUN, clear everything, re-arm
  task automatic rearm();
    set_ret(0, 8, 0, 0, 0);
    en = 0; step();
    clr = 1; en = 1; step();
    clr = 0;
  endtask

  initial begin
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // three retirements streamed straight out
    en = 1; trace_ready = 1; step();
    for (int i = 0; i < 3; i++) begin rand_ret(1); step(); end
    set_ret(0, 8, 0, 0, 0); step();
    chk("stream_cnt_inst", cnt_inst, 32'd3);

    // overfill with the sink stalled
    rearm();
    trace_ready = 0;
    for (int i = 0; i < 10; i++) begin rand_ret(1); step(); end
    chk("ovf_cnt_drop", cnt_drop, 32'd2);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_cnt_inst", cnt_inst, 32'd10);

    // push and pop together while full keeps occupancy, no drop
    trace_ready = 1; rand_ret(1); step();
    chk("full_pushpop_drop", cnt_drop, 32'd2);
    trace_ready = 0; rand_ret(1); step();
    chk("still_full_drop", cnt_drop, 32'd3);

    // memory-size and branch classification
    rearm();
    trace_ready = 0;
    set_ret(1, 2, 0, 0, 0); step();
    set_ret(1, 6, 0, 0, 0); step();
    set_ret(1, DMEM_SIZE_NA, 0, 0, 0); step();
    set_ret(1, DMEM_SIZE_NA, 1, 1, 1); step();
    chk("cls_load", cnt_load, 32'd1);
    chk("cls_store", cnt_store, 32'd1);
    chk("cls_taken", cnt_taken, 32'd1);
    chk("cls_bp_hit", cnt_bp_hit, 32'd1);

    // end of run with four buffered records
    set_ret(0, 8, 0, 0, 0);
    csr_tohost = 32'd1; trace_ready = 1; step();
    csr_tohost = 32'd0;
    for (int i = 0; i < 20 && m_mode != 3; i++) begin rand_ret(1); step(); end
    chk("drain_done", done, 1'b1);
    rand_ret(1); step(); rand_ret(1); step();
    chk("after_done_cnt_inst", cnt_inst, 32'd4);

    // reset mid-run with five buffered records
    clr = 1; step(); clr = 0;
    en = 1; trace_ready = 0; step();
    for (int i = 0; i < 5; i++) begin rand_ret(1); step(); end
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("rst_trace_valid", trace_valid, 1'b0);
    chk("rst_cnt_inst", cnt_inst, 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1; en = 0; trace_ready = 1;
    rand_ret(1); step(); rand_ret(1); step();
    chk("post_rst_idle_cnt", cnt_inst, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      en          = ($urandom_range(0, 19) != 0);
      clr         = ($urandom_range(0, 24) == 0);
      trace_ready = ($urandom_range(0, 2) != 0);
      csr_tohost  = ($urandom_range(0, 39) == 0) ? $urandom | 32'd1 : 32'd0;
      rand_ret($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ama_riscv_ret_trace_buf.md
AMA_RISCV_RET_TRACE_BUF -- requirements
Module: ama_riscv_ret_trace_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, trace FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 32, width of each event counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  core clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port en  in  1  arm tracing (level).
REQ-007 SHALL have port clr  in  1  synchronous clear of FIFO, counters and flags; honoured only in IDLE or DONE.
REQ-008 SHALL have port ret_valid  in  1  instruction retired this cycle.
REQ-009 SHALL have ports ret_inst and ret_pc  in  32 each  retired instruction word and PC.
REQ-010 SHALL have ports ret_branch_inst, ret_branch_taken, ret_bp_hit  in  1 each  branch attributes of the retired instruction.
REQ-011 SHALL have port ret_dmem_addr  in  32  data address; ret_dmem_size  in  4  codes 0-3 load b/h/w/d, 4-7 store b/h/w/d, 8 no access.
REQ-012 SHALL have port csr_tohost  in  32  nonzero requests end of run.
REQ-013 SHALL have ports trace_valid  out  1, trace_ready  in  1, trace_rec  out  trace_rec_t  drain channel.
REQ-014 SHALL have ports cnt_inst, cnt_branch, cnt_taken, cnt_bp_hit, cnt_load, cnt_store, cnt_drop  out  CNT_W each.
REQ-015 SHALL have ports overflow  out  1  sticky drop flag; done  out  1  run finished, FIFO empty.

Function
REQ-016 SHALL implement FSM IDLE -> RUN (en=1) -> DRAIN (csr_tohost!=0, sampled in RUN) -> DONE (FIFO empty in DRAIN); DONE -> IDLE on clr.
REQ-017 SHALL sample ret_* only in RUN; ret_valid outside RUN is ignored entirely (no push, no count).
REQ-018 SHALL, in RUN with en=0, return to IDLE and retain FIFO contents and counters.
REQ-019 SHALL push one record per accepted ret_valid; the record is visible on trace_rec with trace_valid=1 no earlier than the next cycle (1-cycle latency when empty).
REQ-020 SHALL pop on trace_valid && trace_ready; trace_rec SHALL hold stable while trace_valid=1 and trace_ready=0.
REQ-021 SHALL allow push and pop in the same cycle at any occupancy, including full (occupancy unchanged).
REQ-022 SHALL, when full with no pop and ret_valid in RUN, drop the record, increment cnt_drop, and set overflow until clr.
REQ-023 SHALL increment counters once per accepted-or-dropped retirement: cnt_inst always; cnt_branch if ret_branch_inst; cnt_taken if ret_branch_inst && ret_branch_taken; cnt_bp_hit if ret_branch_inst && ret_bp_hit; cnt_load if size<4; cnt_store if 4<=size<=7.
REQ-024 SHALL wrap counters modulo 2^CNT_W; cnt_drop SHALL saturate at all-ones.
REQ-025 SHALL, when csr_tohost goes nonzero in the same cycle as ret_valid, still accept that retirement, then enter DRAIN.
REQ-026 SHALL keep popping in DRAIN and DONE; done=1 exactly in DONE.
REQ-027 SHALL use DEPTH+1-wide-range occupancy (log2(DEPTH)+1 bits) with wrapping read/write pointers; full = occupancy==DEPTH, empty = occupancy==0.

Reset
REQ-028 SHALL on rst_n=0 asynchronously force IDLE, pointers and occupancy 0, trace_valid=0, all counters 0, overflow=0, done=0.
REQ-029 SHALL leave FIFO storage unreset; trace_rec is don't-care while trace_valid=0.
REQ-030 SHALL, on reset mid-run, discard all buffered records.

Structure
REQ-031 SHALL define trace_rec_t (packed: inst, pc, dmem_addr, dmem_size, branch_inst, branch_taken, bp_hit) and the DMEM_SIZE_NA=8 constant in the shared package.
REQ-032 SHALL define the FSM state enum in the shared package.
REQ-033 SHALL instantiate one sub-module ama_riscv_sync_fifo (DEPTH, type parameter) for storage; FSM and counters stay in this module.

Verification
REQ-034 SHALL cover: en=1, 3 retirements, trace_ready=1 -> 3 records in order, each 1 cycle after push, cnt_inst=3.
REQ-035 SHALL cover: DEPTH=8, trace_ready=0, 10 retirements -> 8 stored, cnt_drop=2, overflow=1, cnt_inst=10.
REQ-036 SHALL cover: full FIFO, simultaneous push and pop -> occupancy stays 8, cnt_drop unchanged.
REQ-037 SHALL cover: retirements with size 2, 6, 8 and branch taken with bp_hit -> cnt_load=1, cnt_store=1, cnt_taken=1, cnt_bp_hit=1.
REQ-038 SHALL cover: csr_tohost=1 with 4 buffered records, trace_ready=1 -> DRAIN, done=1 the cycle after last pop; later ret_valid ignored.
REQ-039 SHALL cover: rst_n asserted with 5 buffered records -> trace_valid=0 and all counters 0 immediately, IDLE after release.
